vector_recorder: RTL and testbench

VECTOR_RECORDER -- requirements
Module: vector_recorder

---
 rtl/vector_recorder.sv | 113 +++++++++++
 tb/tb_vector_recorder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_recorder.sv
// vector_recorder: arm/trigger/stop controlled capture of sample vectors into
// an on-chip buffer, followed by a valid/ready readout of the recorded vectors.
`default_nettype none

module vector_recorder #(
  parameter int VECTOR_SIZE = 4,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_arm,
  input  logic                   i_trigger,
  input  logic                   i_sample_en,
  input  logic [VECTOR_SIZE-1:0] i_sample,
  input  logic                   i_stop,
  input  logic                   i_rd_ready,
  output logic                   o_rd_valid,
  output logic [VECTOR_SIZE-1:0] o_rd_data,
  output logic                   o_rd_last,
  output logic [ADDR_WIDTH:0]    o_count,
  output logic [1:0]             o_state,
  output logic                   o_full
);

  localparam int                  DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] c_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [VECTOR_SIZE-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_wr;
  logic w_wr_last;
  logic w_clr;
  logic w_rd_valid;
  logic w_xfer;

  // The write address is the count itself, so it can never wrap past DEPTH.
  assign w_full     = (r_count == c_FULL);
  assign w_wr       = i_sample_en && !w_full &&
                      ((r_state == S_ARMED && i_trigger) || r_state == S_CAPTURE);
  assign w_wr_last  = w_wr && (r_count == c_FULL - c_ONE);
  assign w_clr      = i_arm && (r_state == S_IDLE || r_state == S_DONE);
  assign w_rd_valid = (r_state == S_DONE) && (r_rptr < r_count);
  assign w_xfer     = w_rd_valid && i_rd_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_arm) w_next = S_ARMED;
      end
      S_ARMED: begin
        if (i_stop) w_next = S_DONE;
        else if (i_trigger) w_next = w_wr_last ? S_DONE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (i_stop || w_wr_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (i_arm) w_next = S_ARMED;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_rptr  <= '0;
    end else if (w_clr) begin
      r_count <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_wr)   r_count <= r_count + c_ONE;
      if (w_xfer) r_rptr  <= r_rptr + c_ONE;
    end
  end

  // Buffer contents survive reset; stale entries stay hidden because count is cleared.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_count[ADDR_WIDTH-1:0]] <= i_sample;
  end

  assign o_rd_valid = w_rd_valid;
  assign o_rd_data  = r_mem[r_rptr[ADDR_WIDTH-1:0]];
  assign o_rd_last  = w_rd_valid && (r_rptr == r_count - c_ONE);
  assign o_count    = r_count;
  assign o_state    = r_state;
  assign o_full     = w_full;

endmodule

`default_nettype wire

// File: tb/tb_vector_recorder.sv
// Directed bench for vector_recorder with a queue scoreboard of recorded vectors.
`default_nettype none

module tb_vector_recorder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       trigger = 1'b0;
  logic       sample_en = 1'b0;
  logic [3:0] sample = 4'h0;
  logic       stop = 1'b0;
  logic       rd_ready = 1'b0;

  logic       rd_valid, rd_last, full;
  logic [3:0] rd_data;
  logic [10:0] count;
  logic [1:0] state;

  logic       d2_rd_valid, d2_rd_last, d2_full;
  logic [3:0] d2_rd_data;
  logic [2:0] d2_count;
  logic [1:0] d2_state;

  int total = 0;
  int bad = 0;
  logic [3:0] q[$];

  always #5 clk = ~clk;

  vector_recorder #(.VECTOR_SIZE(4), .ADDR_WIDTH(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_trigger(trigger),
    .i_sample_en(sample_en), .i_sample(sample), .i_stop(stop), .i_rd_ready(rd_ready),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_rd_last(rd_last),
    .o_count(count), .o_state(state), .o_full(full)
  );

  vector_recorder #(.VECTOR_SIZE(4), .ADDR_WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_trigger(trigger),
    .i_sample_en(sample_en), .i_sample(sample), .i_stop(stop), .i_rd_ready(rd_ready),
    .o_rd_valid(d2_rd_valid), .o_rd_data(d2_rd_data), .o_rd_last(d2_rd_last),
    .o_count(d2_count), .o_state(d2_state), .o_full(d2_full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic a, input logic t, input logic se, input logic [3:0] s, input logic st);
    arm = a; trigger = t; sample_en = se; sample = s; stop = st;
  endtask

  // stall_mode 1 drives rd_ready with the repeating pattern 1,0,0,1
  task automatic readout(input int stall_mode, input int limit);
    int cyc = 0;
    int k = 0;
    int xfers = 0;
    while (q.size() > 0 && xfers < limit && cyc < 64) begin
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, q[0]);
      check("rd_last", rd_last, q.size() == 1);
      rd_ready = (stall_mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      k++;
      tick();
      if (rd_ready) begin
        void'(q.pop_front());
        xfers++;
      end
      cyc++;
    end
    rd_ready = 1'b0;
    check("readout_budget", cyc < 64, 1);
    if (q.size() == 0) check("rd_valid_end", rd_valid, 0);
  endtask

  initial begin
    // reset is asynchronous: outputs must be clear before the first edge
    #3;
    check("rst_state", state, 2'b00);
    check("rst_count", count, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_full", full, 0);
    tick();
    rst = 1'b0;

    // basic record 1..4, stop in cycle of sample 4
    drv(1, 1, 0, 4'h0, 0); tick();
    check("arm_trig_same_cycle", state, 2'b01);
    drv(0, 1, 1, 4'h1, 0); q.push_back(4'h1); tick();
    check("capture_state", state, 2'b10);
    check("capture_count1", count, 1);
    drv(0, 0, 1, 4'h2, 0); q.push_back(4'h2); tick();
    drv(0, 0, 1, 4'h3, 0); q.push_back(4'h3); tick();
    drv(0, 0, 1, 4'h4, 1); q.push_back(4'h4); tick();
    drv(0, 0, 0, 4'h0, 0);
    check("stop_state", state, 2'b11);
    check("stop_count", count, 4);
    check("stop_full", full, 0);
    readout(0, 99);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    check("done_after_read", state, 2'b11);
    check("ready_no_valid", rd_valid, 0);

    // stalled readout 5..8
    drv(1, 0, 0, 4'h0, 0); tick();
    drv(0, 1, 1, 4'h5, 0); q.push_back(4'h5); tick();
    drv(0, 0, 1, 4'h6, 0); q.push_back(4'h6); tick();
    drv(0, 0, 0, 4'hF, 0); tick();
    drv(0, 0, 1, 4'h7, 0); q.push_back(4'h7); tick();
    drv(0, 0, 1, 4'h8, 0); q.push_back(4'h8); tick();
    drv(0, 0, 0, 4'h0, 1); tick();
    drv(0, 0, 0, 4'h0, 0);
    check("stall_count", count, 4);
    readout(1, 99);

    // fill a depth-4 buffer with 0..7
    q.delete();
    drv(1, 0, 0, 4'h0, 0); tick();
    for (int i = 0; i < 8; i++) begin
      drv(0, i == 0, 1, i[3:0], 0); tick();
      if (i == 3) begin
        check("d2_full_state", d2_state, 2'b11);
        check("d2_full_count", d2_count, 4);
        check("d2_full_flag", d2_full, 1);
      end
    end
    check("d2_no_overwrite", d2_count, 4);
    check("big_still_capture", state, 2'b10);
    check("big_count8", count, 8);
    drv(0, 0, 0, 4'h0, 1); tick();
    drv(0, 0, 0, 4'h0, 0);
    rd_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("d2_rd_valid", d2_rd_valid, 1);
      check("d2_rd_data", d2_rd_data, j);
      check("d2_rd_last", d2_rd_last, j == 3);
      tick();
    end
    rd_ready = 1'b0;
    check("d2_rd_valid_end", d2_rd_valid, 0);
    check("d2_full_hold", d2_full, 1);

    // arm then stop without trigger; sample_en without trigger is ignored
    drv(1, 0, 0, 4'h0, 0); tick();
    drv(0, 0, 1, 4'h9, 0); tick();
    check("armed_no_write", count, 0);
    check("armed_hold", state, 2'b01);
    drv(0, 0, 0, 4'h0, 1); tick();
    drv(0, 0, 0, 4'h0, 0);
    check("empty_done_state", state, 2'b11);
    check("empty_done_count", count, 0);
    rd_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      check("empty_rd_valid", rd_valid, 0);
      check("empty_rd_last", rd_last, 0);
      tick();
    end
    rd_ready = 1'b0;

    // asynchronous reset mid-capture, then a fresh recording
    drv(1, 0, 0, 4'h0, 0); tick();
    drv(0, 1, 1, 4'hA, 0); tick();
    drv(0, 0, 1, 4'hB, 0); tick();
    check("pre_rst_count", count, 2);
    rst = 1'b1;
    #1;
    check("async_rst_state", state, 2'b00);
    check("async_rst_count", count, 0);
    drv(0, 0, 0, 4'h0, 0);
    tick();
    rst = 1'b0;
    drv(1, 0, 0, 4'h0, 0); tick();
    drv(0, 1, 1, 4'hC, 0); q.push_back(4'hC); tick();
    drv(0, 0, 1, 4'hD, 0); q.push_back(4'hD); tick();
    drv(0, 0, 1, 4'hE, 1); q.push_back(4'hE); tick();
    drv(0, 0, 0, 4'h0, 0);
    check("post_rst_count", count, 3);
    readout(0, 99);

    // partial readout then re-arm; arm during capture is ignored
    drv(1, 0, 0, 4'h0, 0); tick();
    drv(0, 1, 1, 4'h9, 0); q.push_back(4'h9); tick();
    drv(0, 0, 1, 4'hA, 0); q.push_back(4'hA); tick();
    drv(0, 0, 1, 4'hB, 0); q.push_back(4'hB); tick();
    drv(0, 0, 1, 4'hC, 1); q.push_back(4'hC); tick();
    drv(0, 0, 0, 4'h0, 0);
    readout(0, 2);
    check("partial_left", q.size(), 2);
    q.delete();
    drv(1, 0, 0, 4'h0, 0); tick();
    check("rearm_state", state, 2'b01);
    check("rearm_count", count, 0);
    check("rearm_rd_valid", rd_valid, 0);
    drv(0, 1, 1, 4'h3, 0); q.push_back(4'h3); tick();
    drv(1, 0, 1, 4'h6, 0); q.push_back(4'h6); tick();
    check("arm_in_capture_state", state, 2'b10);
    check("arm_in_capture_count", count, 2);
    drv(0, 0, 0, 4'h0, 1); tick();
    drv(0, 0, 0, 4'h0, 0);
    readout(0, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
